// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store sequencer: access sizes and FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_RSP  = 2'b11
  } state_t;

  // Size 2'b11 behaves as a word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Combinational lane logic: extracts/extends a load lane from a memory word and
// merges a byte/half store into a previously read word.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [31:0] i_rd_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_adr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_adr_lo)
      2'b00:   w_byte = i_rd_word[7:0];
      2'b01:   w_byte = i_rd_word[15:8];
      2'b10:   w_byte = i_rd_word[23:16];
      default: w_byte = i_rd_word[31:24];
    endcase
    w_half = i_adr_lo[1] ? i_rd_word[31:16] : i_rd_word[15:0];
  end

  always_comb begin
    o_load_data = i_rd_word;
    if (is_word(i_size)) begin
      o_load_data = i_rd_word;
    end else if (i_size == SZ_HALF) begin
      o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
    end else begin
      o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
    end
  end

  always_comb begin
    o_store_data = i_rd_word;
    if (is_word(i_size)) begin
      o_store_data = i_wdata;
    end else if (i_size == SZ_HALF) begin
      if (i_adr_lo[1]) o_store_data[31:16] = i_wdata[15:0];
      else             o_store_data[15:0]  = i_wdata[15:0];
    end else begin
      case (i_adr_lo)
        2'b00:   o_store_data[7:0]   = i_wdata[7:0];
        2'b01:   o_store_data[15:8]  = i_wdata[7:0];
        2'b10:   o_store_data[23:16] = i_wdata[7:0];
        default: o_store_data[31:24] = i_wdata[7:0];
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Sub-word load/store sequencer in front of a word-only memory (RMW for sb/sh).
// Optional misalignment trap enabled by defining LSU_MISALIGN_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [31:0]       mem_din,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [31:0]       mem_dout
);

  state_t            r_state;
  state_t            w_nxt;
  logic              r_we;
  logic              r_uns;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_adr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rd_q;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_accept;
  logic              w_req_err;
  logic [ADDR_W-1:0] w_wadr;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_load;
  logic [31:0]       w_store;

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_req_err = ((req_size == SZ_HALF) && req_adr[0]) ||
                     (is_word(req_size) && (req_adr[1:0] != 2'b00));
`else
  assign w_req_err = 1'b0;
`endif

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_wadr   = {r_adr[ADDR_W-1:2], 2'b00};
  // Extraction happens while the read is in flight; merging uses the captured word.
  assign w_rd_word = (r_state == S_RD) ? mem_dout : r_rd_q;

  lsu_lane_merge u_lane (
    .i_rd_word    (w_rd_word),
    .i_wdata      (r_wdata),
    .i_adr_lo     (r_adr[1:0]),
    .i_size       (r_size),
    .i_unsigned   (r_uns),
    .o_load_data  (w_load),
    .o_store_data (w_store)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_adr   = '0;
    mem_din   = 32'h0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (w_req_err)                         w_nxt = S_RSP;
          else if (req_we && is_word(req_size)) w_nxt = S_WR;
          else                                   w_nxt = S_RD;
        end
      end
      S_RD: begin
        mem_rd  = 1'b1;
        mem_adr = w_wadr;
        w_nxt   = r_we ? S_WR : S_RSP;
      end
      S_WR: begin
        mem_wr  = 1'b1;
        mem_adr = w_wadr;
        mem_din = w_store;
        w_nxt   = S_RSP;
      end
      default: begin
        rsp_valid = 1'b1;
        w_nxt     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_uns       <= 1'b0;
      r_size      <= SZ_BYTE;
      r_adr       <= '0;
      r_wdata     <= 32'h0;
      r_rd_q      <= 32'h0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_uns   <= req_unsigned;
        r_size  <= req_size;
        r_adr   <= req_adr;
        r_wdata <= req_wdata;
      end
      if (r_state == S_RD) r_rd_q <= mem_dout;
      // Response registers update only on entry to RSP, so they hold between responses.
      if ((w_nxt == S_RSP) && (r_state != S_RSP)) begin
        r_rsp_rdata <= ((r_state == S_RD) && !r_we) ? w_load : 32'h0;
        r_rsp_err   <= (r_state == S_IDLE) ? w_req_err : 1'b0;
      end
    end
  end

  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a 256-word behavioural memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] lat;
    logic [31:0] nrd;
    logic [31:0] nwr;
    logic [31:0] din;
    logic [31:0] adr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_adr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_adr;
  logic [31:0] mem_din;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_dout;

  logic [31:0] mem [0:255];
  exp_t        sb_q[$];
  logic [31:0] n_cmp = 0;
  logic [31:0] n_err = 0;
  logic [31:0] cycle_cnt = 0;
  logic [31:0] acc_cyc = 0;
  logic [31:0] mon_nrd = 0;
  logic [31:0] mon_nwr = 0;
  logic [31:0] mon_din = 0;
  logic [31:0] mon_adr = 0;
  logic [31:0] rsp_seen = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_adr      (req_adr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_adr      (mem_adr),
    .mem_din      (mem_din),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_dout     (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dout = mem[mem_adr[9:2]];
  always @(posedge clk) begin
    cycle_cnt <= cycle_cnt + 1;
    if (mem_wr) mem[mem_adr[9:2]] <= mem_din;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rdata, input logic err, input logic [31:0] lat,
                              input logic [31:0] nrd, input logic [31:0] nwr,
                              input logic [31:0] din, input logic [31:0] adr);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat; e.nrd = nrd; e.nwr = nwr; e.din = din; e.adr = adr;
    return e;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] a);
    logic [31:0] s;
    if (sz == SZ_HALF) begin
      s = w >> (a[1] ? 16 : 0);
      return (!uns && s[15]) ? (s | 32'hFFFF_0000) : (s & 32'h0000_FFFF);
    end
    s = w >> (8 * a);
    return (!uns && s[7]) ? (s | 32'hFFFF_FF00) : (s & 32'h0000_00FF);
  endfunction

  // Monitor: counts memory activity and checks each response against the scoreboard.
  always @(negedge clk) begin
    if (mem_rd) mon_nrd = mon_nrd + 1;
    if (mem_wr) begin
      mon_nwr = mon_nwr + 1;
      mon_din = mem_din;
    end
    if (mem_rd || mem_wr) mon_adr = mem_adr;
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("latency", cycle_cnt - acc_cyc + 1, e.lat);
        chk("mem_rd_cycles", mon_nrd, e.nrd);
        chk("mem_wr_cycles", mon_nwr, e.nwr);
        if (e.nwr != 0) chk("mem_din", mon_din, e.din);
        if ((e.nrd + e.nwr) != 0) chk("mem_adr", mon_adr, e.adr);
      end
      rsp_seen = rsp_seen + 1;
    end
  end

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] adr, input logic [31:0] wd, input exp_t e);
    logic [31:0] seen0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_adr = adr; req_wdata = wd;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_cyc = cycle_cnt;
    mon_nrd = 0;
    mon_nwr = 0;
    seen0 = rsp_seen;
    chk("busy_ready", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < 10 && rsp_seen == seen0; i++) @(posedge clk);
    if (rsp_seen == seen0) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rw;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'h8899_AABB;
    mem[8'hFF] = 32'h1122_3344;
    rw = $urandom;
    mem[8'h41] = rw;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_BYTE;
    req_unsigned = 1'b0; req_adr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_mem_ctl", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst_mem_adr", mem_adr, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    rst = 1'b0;

    do_req(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, mk(32'h8899_AABB, 1'b0, 2, 1, 0, 0, 32'h100));
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h101, 32'h0, mk(32'hFFFF_FFAA, 1'b0, 2, 1, 0, 0, 32'h100));
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h101, 32'h0, mk(32'h0000_00AA, 1'b0, 2, 1, 0, 0, 32'h100));
    do_req(1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0, mk(32'hFFFF_8899, 1'b0, 2, 1, 0, 0, 32'h100));
    do_req(1'b0, SZ_HALF, 1'b1, 32'h102, 32'h0, mk(32'h0000_8899, 1'b0, 2, 1, 0, 0, 32'h100));

    do_req(1'b1, SZ_BYTE, 1'b0, 32'h102, 32'h55, mk(32'h0, 1'b0, 3, 1, 1, 32'h8855_AABB, 32'h100));
    do_req(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, mk(32'h8855_AABB, 1'b0, 2, 1, 0, 0, 32'h100));
    mem[8'h40] = 32'h8899_AABB;
    do_req(1'b1, SZ_HALF, 1'b0, 32'h100, 32'hFFFF_1234, mk(32'h0, 1'b0, 3, 1, 1, 32'h8899_1234, 32'h100));
    do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, mk(32'h8899_1234, 1'b0, 2, 1, 0, 0, 32'h100));
    do_req(1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEAD_BEEF, mk(32'h0, 1'b0, 2, 0, 1, 32'hDEAD_BEEF, 32'h100));
    chk("mem_after_sw", mem[8'h40], 32'hDEAD_BEEF);

    for (int a = 0; a < 4; a++) begin
      do_req(1'b0, SZ_BYTE, 1'b0, 32'h104 + a, 32'h0,
             mk(ref_load(rw, SZ_BYTE, 1'b0, a[1:0]), 1'b0, 2, 1, 0, 0, 32'h104));
      do_req(1'b0, SZ_BYTE, 1'b1, 32'h104 + a, 32'h0,
             mk(ref_load(rw, SZ_BYTE, 1'b1, a[1:0]), 1'b0, 2, 1, 0, 0, 32'h104));
    end
    for (int a = 0; a < 4; a += 2) begin
      do_req(1'b0, SZ_HALF, 1'b0, 32'h104 + a, 32'h0,
             mk(ref_load(rw, SZ_HALF, 1'b0, a[1:0]), 1'b0, 2, 1, 0, 0, 32'h104));
      do_req(1'b0, SZ_HALF, 1'b1, 32'h104 + a, 32'h0,
             mk(ref_load(rw, SZ_HALF, 1'b1, a[1:0]), 1'b0, 2, 1, 0, 0, 32'h104));
    end

    do_req(1'b1, SZ_BYTE, 1'b0, 32'hFFFF_FFFF, 32'h7F, mk(32'h0, 1'b0, 3, 1, 1, 32'h7F22_3344, 32'hFFFF_FFFC));
    do_req(1'b0, SZ_WORD, 1'b0, 32'hFFFF_FFFC, 32'h0, mk(32'h7F22_3344, 1'b0, 2, 1, 0, 0, 32'hFFFF_FFFC));

`ifdef LSU_MISALIGN_CHECK_EN
    do_req(1'b0, SZ_WORD, 1'b0, 32'h101, 32'h0, mk(32'h0, 1'b1, 1, 0, 0, 0, 0));
    do_req(1'b0, SZ_HALF, 1'b0, 32'h103, 32'h0, mk(32'h0, 1'b1, 1, 0, 0, 0, 0));
    do_req(1'b1, SZ_HALF, 1'b0, 32'h101, 32'h5555, mk(32'h0, 1'b1, 1, 0, 0, 0, 0));
    chk("mem_after_misalign", mem[8'h40], 32'hDEAD_BEEF);
`else
    do_req(1'b0, SZ_WORD, 1'b0, 32'h101, 32'h0, mk(32'hDEAD_BEEF, 1'b0, 2, 1, 0, 0, 32'h100));
    do_req(1'b0, SZ_HALF, 1'b0, 32'h103, 32'h0, mk(32'hFFFF_DEAD, 1'b0, 2, 1, 0, 0, 32'h100));
`endif

    // Reset asserted in the WR cycle of an sb: the write must be suppressed.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0;
    req_adr = 32'h100; req_wdata = 32'h66;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("wr_before_rst", {31'd0, mem_wr}, 32'd1);
    rst = 1'b1;
    #1;
    chk("wr_after_rst", {31'd0, mem_wr}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mem_after_rst", mem[8'h40], 32'hDEAD_BEEF);
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
    chk("rsp_after_rst", {31'd0, rsp_valid}, 32'd0);

    do_req(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, mk(32'hDEAD_BEEF, 1'b0, 2, 1, 0, 0, 32'h100));
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
